vga_scanout: RTL and testbench
==============================

# vga_scanout

Display-side consumer of the MiniAlu video memory. Generates 640x480@60 Hz VGA timing from the 50 MHz board clock and issues linear read addresses to the video RAM read port. Registers the returned 3-bit RGB pixel onto the VGA pins, aligned with HSYNC and VSYNC. The CPU writes pixels through the RAM write port; this block only reads.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSYNC pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width
- V_BACK, 33, vertical back porch
- ADDR_WIDTH, 24, video RAM address width

Ports:
- Clock, in, 1, 50 MHz system clock, single clock domain.
- Reset, in, 1, asynchronous, active-high.
- iPixelData, in, 3, RAM read data {R,G,B}. Valid one Clock after oReadAddress changes.
- oReadAddress, out, ADDR_WIDTH, linear pixel address (line*H_VISIBLE + column).
- oVGA_R / oVGA_G / oVGA_B, out, 1 each, pixel colour. Forced to 0 outside the visible area.
- oVGA_HS, out, 1, horizontal sync, active-low.
- oVGA_VS, out, 1, vertical sync, active-low.
- oFrameStart, out, 1, one-Clock pulse on the pixel tick where the position is (0,0).

## Operation
- Pixel tick: rPixelEn toggles every Clock, giving 25 MHz. Counters and output registers advance only when rPixelEn=1.
- Horizontal counter:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK = 800.
  - Counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter:
  - V_TOTAL = 525.
  - Increments on the tick where the horizontal counter wraps.
  - Wraps to 0 after V_TOTAL-1.
- Visible area: hcount < H_VISIBLE and vcount < V_VISIBLE.
- Sync windows (stage-0, before the output register):
  - HSYNC is low while H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC.
  - VSYNC is low under the same rule on vcount, using the V_* parameters.
- Address generator:
  - No multiplier.
  - Increments by 1 on each visible pixel tick.
  - Returns to 0 on the tick where (hcount,vcount) wraps to (0,0).
  - Never exceeds H_VISIBLE*V_VISIBLE-1.
  - Holds its value during blanking.
- Output stage:
  - On each pixel tick, registers iPixelData (or 0 if the previous pixel was not visible), the delayed HS/VS, and the frame-start flag.

## Timing
- Reset values:
  - rPixelEn=0, counters=0, oReadAddress=0.
  - oVGA_R/G/B=0, oVGA_HS=1, oVGA_VS=1, oFrameStart=0.
- Latency: counter position to pins is exactly one pixel tick (2 Clock). RGB, HS and VS share this latency, so they stay mutually aligned.
- RAM timing: the address is stable for 2 Clock. Data is sampled 2 Clock after the address changes, which leaves one cycle of margin over the RAM read latency.
- First frame: the first pixel tick after reset releases outputs pixel (0,0). oFrameStart pulses on the first tick after reset and once every 800*525 ticks after that.
- Boundaries:
  - Last visible pixel (639,479) is read from address 307199.
  - The next address change occurs at the wrap to (0,0), returning to 0.
  - Simultaneous horizontal and vertical wrap resets both counters and the address on the same tick.
- Reset asserted mid-frame: all state returns to reset values asynchronously. Scan restarts at (0,0) after release, with no partial-line artefacts.

## Configuration
- VGA_BORDER_EN:
  - Defined: pixels with hcount in {0, H_VISIBLE-1} or vcount in {0, V_VISIBLE-1} are output as 3'b111, overriding iPixelData. The read address sequence is unchanged.
  - Undefined: no override logic is built, and RAM data passes through unmodified.

## Structure
- Definitions.v gains the standard-mode constants: `VGA_H_VISIBLE, `VGA_H_TOTAL, `VGA_V_VISIBLE, `VGA_V_TOTAL and the sync polarity. The parameter defaults above reference these constants.
- One sub-module, vga_sync_counter:
  - Inputs: pixel tick.
  - Contains the hcount/vcount pair and the wrap logic.
  - Outputs: hcount, vcount, visible, hsync_n, vsync_n, frame_start.
- The address generator and output register stay in vga_scanout.

## Test plan
- Reset released with iPixelData=3'b101 held:
  - First pixel tick gives oFrameStart=1 and RGB=101.
  - oReadAddress sequence 0,1,2 on successive ticks.
- Full line:
  - oVGA_HS goes low at Clock 2*(656+1) after line start and stays low for 192 Clock.
  - RGB is 0 for all blanking ticks.
- Full frame:
  - oVGA_VS is low for exactly 2 lines starting at line 490.
  - oFrameStart period is 840000 Clock.
  - Maximum oReadAddress is 307199, followed by 0.
- RAM model returning address[2:0]: the observed RGB at each visible pixel equals (line*640+column)[2:0], with no one-pixel shift.
- Reset asserted mid-line (hcount≈300, vcount≈100) for 3 Clock: outputs return to reset values immediately, and the scan restarts at address 0.
- With VGA_BORDER_EN defined and iPixelData=000: RGB is 111 on line 0, line 479, column 0 and column 639, and 000 elsewhere in the visible area.

Source files
------------

// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg: shared constants and types for the VGA scan-out path.
//   - Standard 640x480@60 mode constants used as parameter defaults.
//   - Sync polarity of the standard mode.
//   - vgaPins_t: the registered pin bundle (RGB, HSYNC, VSYNC, frame-start).
//   - countWidth(): counter width wide enough for both the line and frame totals.
package vga_scanout_pkg;

    localparam int unsigned VgaHVisible = 640;
    localparam int unsigned VgaHTotal   = 800;
    localparam int unsigned VgaVVisible = 480;
    localparam int unsigned VgaVTotal   = 525;

    // Both syncs are active-low in the 640x480@60 mode.
    localparam logic VgaSyncActive = 1'b0;

    localparam logic [2:0] VgaBorderRgb = 3'b111;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hSyncN;
        logic       vSyncN;
        logic       frameStart;
    } vgaPins_t;

    function automatic int unsigned countWidth(input int unsigned hTotal,
                                               input int unsigned vTotal);
        int unsigned maxTotal;
        maxTotal = (hTotal > vTotal) ? hTotal : vTotal;
        return (maxTotal > 1) ? $clog2(maxTotal) : 1;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: horizontal/vertical position counters with wrap logic and
// the stage-0 (unregistered) timing flags derived from the current position.
// Ports:
//   Clock, Reset     - system clock, asynchronous active-high reset
//   iPixelTick       - counters advance only while this is high
//   oHCount/oVCount  - current position
//   oVisible         - position lies inside the visible area
//   oHSyncN/oVSyncN  - sync levels for the current position
//   oFrameStart      - position is (0,0)
//   oFrameWrap       - next tick wraps the position back to (0,0)
module vga_sync_counter
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = VgaHVisible,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = VgaVVisible,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned COUNT_WIDTH = countWidth(H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
                                                    V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iPixelTick,
    output logic [COUNT_WIDTH-1:0] oHCount,
    output logic [COUNT_WIDTH-1:0] oVCount,
    output logic                   oVisible,
    output logic                   oHSyncN,
    output logic                   oVSyncN,
    output logic                   oFrameStart,
    output logic                   oFrameWrap
);

    localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COUNT_WIDTH-1:0] HLast      = COUNT_WIDTH'(HTotal - 1);
    localparam logic [COUNT_WIDTH-1:0] VLast      = COUNT_WIDTH'(VTotal - 1);
    localparam logic [COUNT_WIDTH-1:0] HVisible   = COUNT_WIDTH'(H_VISIBLE);
    localparam logic [COUNT_WIDTH-1:0] VVisible   = COUNT_WIDTH'(V_VISIBLE);
    localparam logic [COUNT_WIDTH-1:0] HSyncStart = COUNT_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [COUNT_WIDTH-1:0] HSyncEnd   = COUNT_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COUNT_WIDTH-1:0] VSyncStart = COUNT_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [COUNT_WIDTH-1:0] VSyncEnd   = COUNT_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [COUNT_WIDTH-1:0] rHCount;
    logic [COUNT_WIDTH-1:0] rVCount;
    logic                   hWrap;
    logic                   vWrap;

    always_comb begin
        hWrap = (rHCount == HLast);
        vWrap = (rVCount == VLast);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rHCount <= '0;
            rVCount <= '0;
        end else if (iPixelTick) begin
            rHCount <= hWrap ? '0 : rHCount + COUNT_WIDTH'(1);
            // The line counter only moves on the tick that ends a line.
            if (hWrap) begin
                rVCount <= vWrap ? '0 : rVCount + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        oHCount     = rHCount;
        oVCount     = rVCount;
        oVisible    = (rHCount < HVisible) && (rVCount < VVisible);
        oHSyncN     = ((rHCount >= HSyncStart) && (rHCount < HSyncEnd)) ?
                      VgaSyncActive : ~VgaSyncActive;
        oVSyncN     = ((rVCount >= VSyncStart) && (rVCount < VSyncEnd)) ?
                      VgaSyncActive : ~VgaSyncActive;
        oFrameStart = (rHCount == '0) && (rVCount == '0);
        oFrameWrap  = hWrap && vWrap;
    end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA scan-out from the video RAM read port.
// A 25 MHz pixel tick is derived from the 50 MHz Clock. Each tick the current
// position's pixel, syncs and frame-start flag are registered onto the pins,
// so all pins share one tick of latency. The read address tracks the current
// position, giving the RAM a full tick to return data.
// Ports:
//   Clock, Reset        - system clock, asynchronous active-high reset
//   iPixelData          - RAM read data {R,G,B}, valid one Clock after address change
//   oReadAddress        - linear pixel address (line*H_VISIBLE + column)
//   oVGA_R/G/B          - pixel colour, 0 outside the visible area
//   oVGA_HS, oVGA_VS    - active-low syncs
//   oFrameStart         - one-Clock pulse when pixel (0,0) reaches the pins
// Build option: VGA_BORDER_EN draws a white one-pixel frame around the visible
// area, overriding RAM data (addresses unchanged).
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = VgaHVisible,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = VgaHTotal - VgaHVisible - 16 - 96,
    parameter int unsigned V_VISIBLE  = VgaVVisible,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = VgaVTotal - VgaVVisible - 10 - 2,
    parameter int unsigned ADDR_WIDTH = 24
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [2:0]            iPixelData,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    output logic                  oVGA_R,
    output logic                  oVGA_G,
    output logic                  oVGA_B,
    output logic                  oVGA_HS,
    output logic                  oVGA_VS,
    output logic                  oFrameStart
);

    localparam int unsigned CountWidth =
        countWidth(H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
                   V_VISIBLE + V_FRONT + V_SYNC + V_BACK);

    localparam logic [CountWidth-1:0] HLastVisible = CountWidth'(H_VISIBLE - 1);
    localparam logic [CountWidth-1:0] VLastVisible = CountWidth'(V_VISIBLE - 1);

    logic                  rPixelEn;
    logic [ADDR_WIDTH-1:0] rAddress;
    logic [ADDR_WIDTH-1:0] addressNext;
    vgaPins_t              rPins;
    vgaPins_t              pinsNext;

    logic [CountWidth-1:0] hCount;
    logic [CountWidth-1:0] vCount;
    logic                  visible;
    logic                  hSyncN;
    logic                  vSyncN;
    logic                  frameStart;
    logic                  frameWrap;
    logic                  lastPixel;

    vga_sync_counter #(
        .H_VISIBLE   (H_VISIBLE),
        .H_FRONT     (H_FRONT),
        .H_SYNC      (H_SYNC),
        .H_BACK      (H_BACK),
        .V_VISIBLE   (V_VISIBLE),
        .V_FRONT     (V_FRONT),
        .V_SYNC      (V_SYNC),
        .V_BACK      (V_BACK),
        .COUNT_WIDTH (CountWidth)
    ) uSyncCounter (
        .Clock       (Clock),
        .Reset       (Reset),
        .iPixelTick  (rPixelEn),
        .oHCount     (hCount),
        .oVCount     (vCount),
        .oVisible    (visible),
        .oHSyncN     (hSyncN),
        .oVSyncN     (vSyncN),
        .oFrameStart (frameStart),
        .oFrameWrap  (frameWrap)
    );

    // Incrementing on the last column of a line lands on the next line's first
    // address, which then holds through blanking. The very last pixel of the
    // frame holds instead, so the address never leaves the frame buffer.
    always_comb begin
        lastPixel   = (hCount == HLastVisible) && (vCount == VLastVisible);
        addressNext = rAddress;
        if (frameWrap) begin
            addressNext = '0;
        end else if (visible && !lastPixel) begin
            addressNext = rAddress + ADDR_WIDTH'(1);
        end
    end

`ifdef VGA_BORDER_EN
    logic borderPixel;

    always_comb begin
        borderPixel = (hCount == '0) || (hCount == HLastVisible) ||
                      (vCount == '0) || (vCount == VLastVisible);
    end
`endif

    always_comb begin
        pinsNext.hSyncN     = hSyncN;
        pinsNext.vSyncN     = vSyncN;
        pinsNext.frameStart = frameStart;
        if (!visible) begin
            pinsNext.rgb = 3'b000;
`ifdef VGA_BORDER_EN
        end else if (borderPixel) begin
            pinsNext.rgb = VgaBorderRgb;
`endif
        end else begin
            pinsNext.rgb = iPixelData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rPixelEn <= 1'b0;
            rAddress <= '0;
            rPins    <= '{rgb: 3'b000, hSyncN: 1'b1, vSyncN: 1'b1, frameStart: 1'b0};
        end else begin
            rPixelEn <= ~rPixelEn;
            // Frame-start is a single-Clock pulse, not held for the whole tick.
            rPins.frameStart <= 1'b0;
            if (rPixelEn) begin
                rAddress <= addressNext;
                rPins    <= pinsNext;
            end
        end
    end

    always_comb begin
        oReadAddress = rAddress;
        oVGA_R       = rPins.rgb[2];
        oVGA_G       = rPins.rgb[1];
        oVGA_B       = rPins.rgb[0];
        oVGA_HS      = rPins.hSyncN;
        oVGA_VS      = rPins.vSyncN;
        oFrameStart  = rPins.frameStart;
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout. Horizontal timing uses the real 640x480
// numbers; the frame is shortened to 12 lines (6 visible) to keep runtime small.
module tb_vga_scanout;

    localparam int HV = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VV = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FrameTicks = HT * VT;

    logic        Clock;
    logic        Reset;
    logic [2:0]  iPixelData;
    logic [23:0] oReadAddress;
    logic        oVGA_R;
    logic        oVGA_G;
    logic        oVGA_B;
    logic        oVGA_HS;
    logic        oVGA_VS;
    logic        oFrameStart;

    logic        useModel;
    logic [2:0]  constData;
    logic [2:0]  ramData;

    int total;
    int bad;

    vga_scanout #(
        .H_VISIBLE  (HV),
        .H_FRONT    (HF),
        .H_SYNC     (HS),
        .H_BACK     (HB),
        .V_VISIBLE  (VV),
        .V_FRONT    (VF),
        .V_SYNC     (VS),
        .V_BACK     (VB),
        .ADDR_WIDTH (24)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iPixelData   (iPixelData),
        .oReadAddress (oReadAddress),
        .oVGA_R       (oVGA_R),
        .oVGA_G       (oVGA_G),
        .oVGA_B       (oVGA_B),
        .oVGA_HS      (oVGA_HS),
        .oVGA_VS      (oVGA_VS),
        .oFrameStart  (oFrameStart)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // RAM model with one Clock read latency, returning address[2:0].
    always @(posedge Clock) ramData <= oReadAddress[2:0];
    assign iPixelData = useModel ? ramData : constData;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance from one negedge to the negedge after the next pixel tick.
    task automatic advanceTick();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
    endtask

    function automatic logic [2:0] expRgb(input int h, input int v, input logic [2:0] data);
        if (h >= HV || v >= VV) return 3'b000;
`ifdef VGA_BORDER_EN
        if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) return 3'b111;
`endif
        return data;
    endfunction

    // Address presented while the scan sits at (h,v).
    function automatic int addrOf(input int h, input int v);
        if (v >= VV) return VV * HV - 1;
        if (h < HV) return v * HV + h;
        if (v == VV - 1) return VV * HV - 1;
        return (v + 1) * HV;
    endfunction

    function automatic logic [2:0] rgbPins();
        return {oVGA_R, oVGA_G, oVGA_B};
    endfunction

    task automatic checkResetPins(input string phase);
        check({phase, "_rgb"}, 32'(rgbPins()), 32'd0);
        check({phase, "_hs"}, 32'(oVGA_HS), 32'd1);
        check({phase, "_vs"}, 32'(oVGA_VS), 32'd1);
        check({phase, "_fs"}, 32'(oFrameStart), 32'd0);
        check({phase, "_addr"}, 32'(oReadAddress), 32'd0);
    endtask

    initial begin
        int h;
        int v;
        int nh;
        int nv;
        total     = 0;
        bad       = 0;
        useModel  = 1'b0;
        constData = 3'b101;
        Reset     = 1'b1;

        // Reset values with constant RAM data.
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checkResetPins("reset");

        Reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check("pre_tick_addr", 32'(oReadAddress), 32'd0);
        check("pre_tick_fs", 32'(oFrameStart), 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        check("tick0_fs", 32'(oFrameStart), 32'd1);
        check("tick0_rgb", 32'(rgbPins()), 32'(expRgb(0, 0, 3'b101)));
        check("tick0_addr", 32'(oReadAddress), 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        check("fs_pulse_width", 32'(oFrameStart), 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        check("tick1_addr", 32'(oReadAddress), 32'd2);
        check("tick1_rgb", 32'(rgbPins()), 32'(expRgb(1, 0, 3'b101)));

        // Full frame plus the wrap tick, with the address-echo RAM model.
        Reset = 1'b1;
        useModel = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k <= FrameTicks; k++) begin
            advanceTick();
            h  = k % HT;
            v  = (k / HT) % VT;
            nh = (h == HT - 1) ? 0 : h + 1;
            nv = (h == HT - 1) ? ((v == VT - 1) ? 0 : v + 1) : v;
            check("frame_rgb", 32'(rgbPins()), 32'(expRgb(h, v, 3'((v * HV + h) % 8))));
            check("frame_hs", 32'(oVGA_HS), (h >= HV + HF && h < HV + HF + HS) ? 32'd0 : 32'd1);
            check("frame_vs", 32'(oVGA_VS), (v >= VV + VF && v < VV + VF + VS) ? 32'd0 : 32'd1);
            check("frame_fs", 32'(oFrameStart), (h == 0 && v == 0) ? 32'd1 : 32'd0);
            check("frame_addr", 32'(oReadAddress), 32'(addrOf(nh, nv)));
        end

        // Run to (300,3) in the second frame, then reset mid-line.
        for (int k = FrameTicks + 1; k <= FrameTicks + 3 * HT + 300; k++) begin
            advanceTick();
        end
        check("midline_rgb", 32'(rgbPins()), 32'(expRgb(300, 3, 3'((3 * HV + 300) % 8))));
        check("midline_addr", 32'(oReadAddress), 32'(addrOf(301, 3)));
        #3;
        Reset = 1'b1;
        #1;
        checkResetPins("async_reset");
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        check("restart_addr0", 32'(oReadAddress), 32'd0);
        for (int k = 0; k < 3; k++) begin
            advanceTick();
            check("restart_rgb", 32'(rgbPins()), 32'(expRgb(k, 0, 3'(k))));
            check("restart_addr", 32'(oReadAddress), 32'(k + 1));
            check("restart_fs", 32'(oFrameStart), (k == 0) ? 32'd1 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
